// File: rtl/mipi_dsi_pkt_gen.sv
// mipi_dsi_pkt_gen: MIPI DSI packet generator (header + ECC, payload, CRC, inter-packet gap).
// Optional feature: define DSI_PKT_CRC_EN to compute the payload CRC-16; otherwise the CRC word is zero.
module mipi_dsi_pkt_gen #(
    parameter int GAP_CYC = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pkt_start,
    input  logic        pkt_long,
    input  logic [1:0]  pkt_vc,
    input  logic [5:0]  pkt_dt,
    input  logic [15:0] pkt_wc,
    output logic        pkt_ready,
    input  logic [31:0] pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic        hs_en,
    output logic [31:0] hs_data,
    output logic        err_wc,
    output logic        err_underrun
);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, GAP} state_t;

    state_t        state_q, state_d;
    logic [23:0]   hdr_q, hdr_d;
    logic          long_q, long_d;
    logic [13:0]   rem_q, rem_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          hs_en_q, hs_en_d;
    logic [31:0]   hs_data_q, hs_data_d;
    logic          err_wc_q, err_wc_d;
    logic          err_ur_q, err_ur_d;
    logic [15:0]   crc_val;
    logic          accept;

    // DSI Hamming parity over the 24 header bits {WC, DI}; top two ECC bits are zero
    function automatic logic [7:0] ecc(input logic [23:0] d);
        logic [5:0] e;
        e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, e};
    endfunction

    assign pkt_ready    = (state_q == IDLE);
    assign pl_ready     = (state_q == PAYLOAD);
    assign accept       = pl_ready && pl_valid;
    assign hs_en        = hs_en_q;
    assign hs_data      = hs_data_q;
    assign err_wc       = err_wc_q;
    assign err_underrun = err_ur_q;

`ifdef DSI_PKT_CRC_EN
    logic [15:0] crc_q, crc_d;

    // Reflected CRC-16 (poly 0x1021 -> 0x8408), 32 payload bits per cycle, bit 0 first
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 32; i++) r = {1'b0, r[15:1]} ^ ({16{r[0] ^ w[i]}} & 16'h8408);
        return r;
    endfunction

    // CRC restarts in IDLE and folds in every accepted payload word
    always_comb begin
        crc_d = (state_q == IDLE) ? 16'hFFFF : (accept ? crc_upd(crc_q, pl_data) : crc_q);
    end

    // CRC register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) crc_q <= 16'hFFFF;
        else        crc_q <= crc_d;
    end

    assign crc_val = crc_q;
`else
    assign crc_val = 16'h0000;
`endif

    // Next-state and registered-output logic for the packet sequencer
    always_comb begin
        state_d   = state_q;
        hdr_d     = hdr_q;
        long_d    = long_q;
        rem_d     = rem_q;
        gap_d     = gap_q;
        hs_en_d   = 1'b0;
        hs_data_d = 32'h0;
        err_wc_d  = 1'b0;
        err_ur_d  = err_ur_q;
        case (state_q)
            IDLE: begin
                if (pkt_start) begin
                    if (pkt_long && pkt_wc[1:0] != 2'b00) begin
                        err_wc_d = 1'b1;
                    end else begin
                        hdr_d   = {pkt_wc, pkt_vc, pkt_dt};
                        long_d  = pkt_long;
                        state_d = HDR;
                    end
                end
            end
            HDR: begin
                hs_en_d   = 1'b1;
                hs_data_d = {ecc(hdr_q), hdr_q};
                rem_d     = hdr_q[23:10];
                gap_d     = '0;
                state_d   = !long_q ? GAP : (hdr_q[23:10] == 14'd0 ? CRC : PAYLOAD);
            end
            PAYLOAD: begin
                if (pl_valid) begin
                    hs_en_d   = 1'b1;
                    hs_data_d = pl_data;
                    rem_d     = rem_q - 14'd1;
                    state_d   = (rem_q == 14'd1) ? CRC : PAYLOAD;
                end else begin
                    err_ur_d = 1'b1;
                end
            end
            CRC: begin
                hs_en_d   = 1'b1;
                hs_data_d = {16'h0000, crc_val};
                gap_d     = '0;
                state_d   = GAP;
            end
            GAP: begin
                state_d = (gap_q == GW'(GAP_CYC - 1)) ? IDLE : GAP;
                gap_d   = (gap_q == GW'(GAP_CYC - 1)) ? '0 : gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, latched header fields, counters and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            hdr_q     <= '0;
            long_q    <= 1'b0;
            rem_q     <= '0;
            gap_q     <= '0;
            hs_en_q   <= 1'b0;
            hs_data_q <= 32'h0;
            err_wc_q  <= 1'b0;
            err_ur_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            hdr_q     <= hdr_d;
            long_q    <= long_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            hs_en_q   <= hs_en_d;
            hs_data_q <= hs_data_d;
            err_wc_q  <= err_wc_d;
            err_ur_q  <= err_ur_d;
        end
    end
endmodule

// File: tb/tb_mipi_dsi_pkt_gen.sv
// tb_mipi_dsi_pkt_gen: directed self-checking bench for the DSI packet generator.
module tb_mipi_dsi_pkt_gen;
`ifdef DSI_PKT_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif
    localparam logic [31:0] W0 = 32'h1122_3344;
    localparam logic [31:0] W1 = 32'hA5A5_0F0F;
    localparam logic [31:0] W2 = 32'hDEAD_BEEF;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        pkt_start = 1'b0, pkt_long = 1'b0;
    logic [1:0]  pkt_vc = '0;
    logic [5:0]  pkt_dt = '0;
    logic [15:0] pkt_wc = '0;
    logic        pkt_ready;
    logic [31:0] pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic        hs_en;
    logic [31:0] hs_data;
    logic        err_wc, err_underrun;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mipi_dsi_pkt_gen #(.GAP_CYC(32)) dut (
        .clk(clk), .rst_n(rst_n), .pkt_start(pkt_start), .pkt_long(pkt_long),
        .pkt_vc(pkt_vc), .pkt_dt(pkt_dt), .pkt_wc(pkt_wc), .pkt_ready(pkt_ready),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .hs_en(hs_en), .hs_data(hs_data), .err_wc(err_wc), .err_underrun(err_underrun)
    );

    // byte-wise reflected CRC-16/0x8408 reference
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [31:0] w);
        logic [15:0] r;
        r = c;
        for (int k = 0; k < 4; k++) begin
            r = r ^ {8'h00, w[8*k +: 8]};
            for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_word(input logic [15:0] c);
        return CRC_EN ? {16'h0000, c} : 32'h0;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!pkt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!pkt_ready) begin
            checks++; errors++;
            $display("FAIL wait_ready: pkt_ready=%b required 1 within 200 cycles", pkt_ready);
        end
    endtask

    task automatic send(input logic lng, input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
        wait_ready();
        pkt_long = lng; pkt_vc = vc; pkt_dt = dt; pkt_wc = wc; pkt_start = 1'b1;
        @(negedge clk);
        pkt_start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++; if (hs_en !== 1'b0) begin errors++; $display("FAIL rst_hs_en: got %b want 0", hs_en); end
        checks++; if (hs_data !== 32'h0) begin errors++; $display("FAIL rst_hs_data: got %h want 0", hs_data); end
        checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL rst_pl_ready: got %b want 0", pl_ready); end
        checks++; if (err_wc !== 1'b0 || err_underrun !== 1'b0) begin errors++; $display("FAIL rst_err: got %b%b want 00", err_wc, err_underrun); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL rst_pkt_ready: got %b want 1", pkt_ready); end
    endtask

    task automatic test_short();
        int bad = 0, rdy = 0;
        send(1'b0, 2'd0, 6'h05, 16'h0011);
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== 32'h3600_1105) begin errors++; $display("FAIL short_a: hs_en=%b hs_data=%h want 1 36001105", hs_en, hs_data); end
        for (int i = 0; i < 32; i++) begin
            pkt_start = (i == 5);
            @(negedge clk);
            if (hs_en !== 1'b0 || hs_data !== 32'h0) bad++;
            if (i < 31 && pkt_ready) rdy++;
        end
        pkt_start = 1'b0;
        checks++; if (bad != 0) begin errors++; $display("FAIL short_gap: %0d active gap cycles want 0", bad); end
        checks++; if (rdy != 0) begin errors++; $display("FAIL gap_ready: %0d early ready cycles want 0", rdy); end
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL gap_end: pkt_ready=%b want 1", pkt_ready); end
        send(1'b0, 2'd0, 6'h05, 16'h0029);
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== 32'h1C00_2905) begin errors++; $display("FAIL short_b: hs_en=%b hs_data=%h want 1 1c002905", hs_en, hs_data); end
        @(negedge clk);
        checks++; if (hs_en !== 1'b0) begin errors++; $display("FAIL short_b_one: hs_en=%b want 0", hs_en); end
    endtask

    task automatic test_long();
        logic [15:0] c;
        c = crc_step(crc_step(16'hFFFF, W0), W1);
        send(1'b1, 2'd0, 6'h39, 16'd8);
        pl_valid = 1'b1; pl_data = W0;
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== 32'h2A00_0839) begin errors++; $display("FAIL long_hdr: hs_en=%b hs_data=%h want 1 2a000839", hs_en, hs_data); end
        checks++; if (pl_ready !== 1'b1) begin errors++; $display("FAIL long_pl_ready: got %b want 1", pl_ready); end
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== W0) begin errors++; $display("FAIL long_p0: hs_en=%b hs_data=%h want 1 %h", hs_en, hs_data, W0); end
        pl_data = W1;
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== W1) begin errors++; $display("FAIL long_p1: hs_en=%b hs_data=%h want 1 %h", hs_en, hs_data, W1); end
        checks++; if (pl_ready !== 1'b0) begin errors++; $display("FAIL long_pl_drop: got %b want 0", pl_ready); end
        @(negedge clk);
        pl_valid = 1'b0;
        checks++; if (hs_en !== 1'b1 || hs_data !== crc_word(c)) begin errors++; $display("FAIL long_crc: hs_en=%b hs_data=%h want 1 %h", hs_en, hs_data, crc_word(c)); end
        @(negedge clk);
        checks++; if (hs_en !== 1'b0 || err_underrun !== 1'b0) begin errors++; $display("FAIL long_end: hs_en=%b err_underrun=%b want 0 0", hs_en, err_underrun); end
    endtask

    task automatic test_long_wc0();
        send(1'b1, 2'd0, 6'h29, 16'd0);
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== 32'h1C00_0029) begin errors++; $display("FAIL wc0_hdr: hs_en=%b hs_data=%h want 1 1c000029", hs_en, hs_data); end
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== crc_word(16'hFFFF)) begin errors++; $display("FAIL wc0_crc: hs_en=%b hs_data=%h want 1 %h", hs_en, hs_data, crc_word(16'hFFFF)); end
    endtask

    task automatic test_bad_wc();
        int act = 0, pulses = 0;
        send(1'b1, 2'd0, 6'h39, 16'd6);
        checks++; if (err_wc !== 1'b1 || hs_en !== 1'b0 || pkt_ready !== 1'b1) begin errors++; $display("FAIL badwc_pulse: err_wc=%b hs_en=%b pkt_ready=%b want 1 0 1", err_wc, hs_en, pkt_ready); end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (hs_en !== 1'b0 || pkt_ready !== 1'b1) act++;
            if (err_wc) pulses++;
        end
        checks++; if (act != 0) begin errors++; $display("FAIL badwc_idle: %0d bad cycles want 0", act); end
        checks++; if (pulses != 0) begin errors++; $display("FAIL badwc_once: %0d extra pulses want 0", pulses); end
    endtask

    task automatic test_underrun();
        int hole = 0;
        logic [15:0] c;
        c = crc_step(crc_step(crc_step(16'hFFFF, W0), W1), W2);
        send(1'b1, 2'd1, 6'h39, 16'd12);
        pl_valid = 1'b1; pl_data = W0;
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== 32'h1F00_0C79) begin errors++; $display("FAIL ur_hdr: hs_en=%b hs_data=%h want 1 1f000c79", hs_en, hs_data); end
        @(negedge clk);
        checks++; if (hs_data !== W0) begin errors++; $display("FAIL ur_p0: hs_data=%h want %h", hs_data, W0); end
        pl_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (hs_en === 1'b0 && hs_data === 32'h0) hole++;
        end
        pl_valid = 1'b1; pl_data = W1;
        checks++; if (hole != 3) begin errors++; $display("FAIL ur_hole: %0d idle cycles want 3", hole); end
        checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL ur_flag: got %b want 1", err_underrun); end
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== W1) begin errors++; $display("FAIL ur_p1: hs_en=%b hs_data=%h want 1 %h", hs_en, hs_data, W1); end
        pl_data = W2;
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== W2) begin errors++; $display("FAIL ur_p2: hs_en=%b hs_data=%h want 1 %h", hs_en, hs_data, W2); end
        pl_valid = 1'b0;
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== crc_word(c)) begin errors++; $display("FAIL ur_crc: hs_en=%b hs_data=%h want 1 %h", hs_en, hs_data, crc_word(c)); end
        wait_ready();
        checks++; if (err_underrun !== 1'b1) begin errors++; $display("FAIL ur_sticky: got %b want 1", err_underrun); end
    endtask

    task automatic test_mid_reset();
        send(1'b1, 2'd0, 6'h39, 16'd8);
        pl_valid = 1'b1; pl_data = W0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (hs_en !== 1'b0 || hs_data !== 32'h0) begin errors++; $display("FAIL mrst_hs: hs_en=%b hs_data=%h want 0 0", hs_en, hs_data); end
        checks++; if (err_underrun !== 1'b0 || pl_ready !== 1'b0) begin errors++; $display("FAIL mrst_flags: err_underrun=%b pl_ready=%b want 0 0", err_underrun, pl_ready); end
        @(negedge clk);
        rst_n = 1'b1; pl_valid = 1'b0;
        @(negedge clk);
        checks++; if (pkt_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b want 1", pkt_ready); end
        send(1'b0, 2'd0, 6'h05, 16'h0011);
        @(negedge clk);
        checks++; if (hs_en !== 1'b1 || hs_data !== 32'h3600_1105) begin errors++; $display("FAIL mrst_nogap: hs_en=%b hs_data=%h want 1 36001105", hs_en, hs_data); end
    endtask

    initial begin
        test_reset();
        test_short();
        wait_ready();
        test_long();
        wait_ready();
        test_long_wc0();
        wait_ready();
        test_bad_wc();
        test_underrun();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
